ins_loader: RTL

INS_LOADER -- requirements
Module: ins_loader

---
 rtl/ins_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ins_loader.sv
// Streaming instruction loader: takes a word-count header byte and then big-endian
// 4-byte words, and writes them to instruction memory while holding the CPU.
module ins_loader #(
  parameter int          NUM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrDir,
  output logic [31:0] WrDato,
  output logic        CpuHold,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  DbgState
);

  // Handshake: a byte moves on a rising edge only when ByteValid and ByteReady are both 1;
  // the source must hold ByteIn stable while ByteValid is high and ByteReady is low.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [31:0] NUM_WORDS_W = 32'(NUM_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [7:0]  n_q, n_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] dato_q, dato_d;
  logic        xfer;

  assign xfer = ByteValid && ByteReady;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bidx_q  <= '0;
      n_q     <= '0;
      asm_q   <= '0;
      dir_q   <= '0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      n_q     <= n_d;
      asm_q   <= asm_d;
      dir_q   <= dir_d;
      dato_q  <= dato_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    n_d     = n_q;
    asm_d   = asm_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_HDR;
          idx_d   = '0;
          bidx_d  = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          n_d = ByteIn;
          if (ByteIn == 8'd0)                     state_d = S_DONE;
          else if ({24'd0, ByteIn} > NUM_WORDS_W) state_d = S_ERR;
          else                                    state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          bidx_d = bidx_q + 2'd1;
          // Output registers load here so WrDir/WrDato are stable for the whole WRITE cycle
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
            dato_d  = {asm_q, ByteIn};
            dir_d   = BASE_ADDR + {22'd0, idx_q, 2'b00};
          end else begin
            asm_d = {asm_q[15:0], ByteIn};
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = ((idx_q + 8'd1) == n_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ByteReady = (state_q == S_HDR) || (state_q == S_LOAD);
    WrEn      = (state_q == S_WRITE);
    CpuHold   = (state_q != S_DONE);
    Done      = (state_q == S_DONE);
    Err       = (state_q == S_ERR);
    WrDir     = dir_q;
    WrDato    = dato_q;
    DbgState  = state_q;
  end

endmodule
